// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port, 1-cycle-latency memory between an
//                instruction-fetch port and a load/store port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_ls
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;
    localparam logic [3:0] c_MAX_WAIT  = 4'(MAX_WAIT);

    logic [1:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic              r_grant_ls;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_en;
    logic              r_if_ack;
    logic              r_ls_ack;
    logic              r_busy;

    logic              w_any_req;
    logic              w_pick_ls;

    assign w_any_req = if_req | ls_req;
    // Load/store has priority until fetch has lost MAX_WAIT decisions in a row.
    assign w_pick_ls = ls_req & ~(if_req & (r_wait_cnt == c_MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_grant_ls <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mem_en   <= 1'b0;
            r_if_ack   <= 1'b0;
            r_ls_ack   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_if_ack <= 1'b0;
                    r_ls_ack <= 1'b0;
                    if (w_any_req) begin
                        r_grant_ls <= w_pick_ls;
                        r_addr     <= w_pick_ls ? ls_addr : if_addr;
                        r_we       <= w_pick_ls & ls_we;
                        r_wdata    <= (w_pick_ls & ls_we) ? ls_wdata : '0;
                        if (w_pick_ls && if_req) begin
                            r_wait_cnt <= (r_wait_cnt >= c_MAX_WAIT) ? c_MAX_WAIT
                                                                     : r_wait_cnt + 4'd1;
                        end else begin
                            r_wait_cnt <= 4'd0;
                        end
                        r_mem_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_if_ack <= ~r_grant_ls;
                    r_ls_ack <= r_grant_ls;
                    r_state  <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    r_if_ack <= 1'b0;
                    r_ls_ack <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_if_ack <= 1'b0;
                    r_ls_ack <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_en & r_we;
    assign mem_addr  = r_mem_en ? r_addr : '0;
    assign mem_wdata = r_mem_en ? r_wdata : '0;
    assign if_ack    = r_if_ack;
    assign ls_ack    = r_ls_ack;
    // Read data arrives from memory in the ack cycle, so it is steered, not stored.
    assign if_rdata  = r_if_ack ? mem_rdata : '0;
    assign ls_rdata  = (r_ls_ack & ~r_we) ? mem_rdata : '0;
    assign busy      = r_busy;
    assign grant_ls  = r_grant_ls;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_WAIT, 4, consecutive fetch losses before fetch is forced to win (range 1..15)

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  instruction-fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DATA_W  fetch data, valid while if_ack=1
- ls_req  in  1  load/store request, held until ls_ack
- ls_we  in  1  1=store, 0=load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_ack  out  1  one-cycle load/store completion pulse
- ls_rdata  out  DATA_W  load data, valid while ls_ack=1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a mem_en=1 read cycle
- busy  out  1  1 in any state other than IDLE
- grant_ls  out  1  owner of current/last transaction (1=ls, 0=if)

Function
REQ-003 The block SHALL share one single-port, one-cycle-read-latency memory between the fetch and load/store ports, with exactly one transaction outstanding at a time.
REQ-004 The FSM SHALL have states IDLE, ACCESS and RESP; every transition SHALL occur on a rising clk edge.
REQ-005 IDLE: if if_req or ls_req is 1, the block SHALL select a winner, capture the winner's address (and, for ls, we and wdata) into registers, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-006 ACCESS: mem_en SHALL be 1; mem_addr, mem_we and mem_wdata SHALL come from the captured registers (mem_we=0 and mem_wdata=0 for fetch); the next state SHALL be RESP.
REQ-007 RESP: mem_en and mem_we SHALL be 0; the winner's ack SHALL be 1 for exactly this cycle; the next state SHALL be IDLE.
REQ-008 Load/fetch rdata SHALL equal mem_rdata during the ack cycle; ls_rdata SHALL be 0 on a store ack; the non-acked port's rdata SHALL be 0.
REQ-009 Latency SHALL be fixed: a request seen in IDLE at cycle N gives mem_en at N+1 and ack at N+2. Minimum spacing between back-to-back transactions SHALL be 3 cycles.
REQ-010 Requester inputs SHALL be sampled only in IDLE; address or data changes after capture SHALL be ignored.
REQ-011 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-012 If a req drops before its ack, the captured transaction SHALL still complete and ack SHALL still pulse.
REQ-013 Arbitration: when only one req is 1, that port SHALL win. When both are 1, ls SHALL win unless wait_cnt == MAX_WAIT, in which case if SHALL win.
REQ-014 wait_cnt (4-bit) SHALL update only at IDLE grant decisions:
- +1, saturating at MAX_WAIT, when if_req=1 and ls wins
- cleared to 0 when if wins
- cleared to 0 when if_req=0 at a grant decision
REQ-015 grant_ls SHALL be updated at each grant and hold its value until the next grant.
REQ-016 At most one of if_ack and ls_ack SHALL be 1 in any cycle, and an ack SHALL never occur without a preceding ACCESS cycle.

Reset
REQ-017 While rst=1 at a rising edge, the block SHALL enter IDLE and clear wait_cnt, the captured registers and grant_ls to 0.
REQ-018 After reset, all outputs SHALL be 0 (if_ack, ls_ack, if_rdata, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_ls).
REQ-019 A reset during ACCESS or RESP SHALL abort the transaction with no ack; a request still held afterwards SHALL be re-arbitrated from IDLE.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Fetch only: if_req=1, if_addr=0x0010, memory holds 0x1234 at 0x0010 -> mem_en=1 with mem_addr=0x0010 at N+1; if_ack=1 with if_rdata=0x1234 at N+2.
- Store then load: ls_we=1, addr 0x0200, wdata 0xBEEF, then ls_we=0, same addr -> mem_we=1 only in the store's ACCESS cycle; ls_rdata=0 on the store ack; load ack returns 0xBEEF.
- Contention and starvation guard: if_req and ls_req held continuously, MAX_WAIT=4 -> grant order ls,ls,ls,ls,if repeating; acks spaced 3 cycles apart.
- Reset in ACCESS: rst=1 during a load's ACCESS cycle -> no ls_ack, all outputs 0, busy=0; held ls_req re-granted and acked 3 cycles after rst falls.
- Mid-transaction change: if_addr changes from 0x0010 to 0x0020 during ACCESS -> mem_addr stays 0x0010; data returned is from 0x0010.
